apb_slave_mem: RTL



---
 rtl/apb_slv_pkg.sv | 20 ++
 rtl/apb_slv_mem_array.sv | 37 +++
 rtl/apb_slave_mem.sv | 125 ++++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and sizing helpers for the APB scratch-RAM slave.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int WAIT_CNT_W = 4;

   function automatic int lsb_of(input int pdata_size);
      return $clog2(pdata_size / 8);
   endfunction

   function automatic int idx_w_of(input int mem_depth);
      return $clog2(mem_depth);
   endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// The whole array clears on reset so reads after reset return zero.
module apb_slv_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic                we,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [IDX_W-1:0]    widx,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic                rd_zero,
   input  logic [IDX_W-1:0]    ridx,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
               if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
         // An errored read captures zero instead of the aliased word.
         if (re) rdata <= rd_zero ? '0 : mem[ridx];
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave scratch RAM with fixed wait states and byte-strobed writes.
// Define APB_SLV_ERR_EN to report out-of-range / misaligned accesses on PSLVERR.
//
// state  | meaning
// IDLE   | no transfer in progress; a setup cycle is recognised here from PSEL & !PENABLE
// SETUP  | setup cycle: load wait counter, capture read data, latch address error
// ACCESS | access cycles; PREADY high when the wait counter reaches zero
module apb_slave_mem #(
   parameter int PADDR_SIZE  = 32,
   parameter int PDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [2:0]              PPROT,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);
   import apb_slv_pkg::*;

   localparam int LSB   = lsb_of(PDATA_SIZE);
   localparam int IDX_W = idx_w_of(MEM_DEPTH);

   apb_state_t            state;
   apb_state_t            phase;
   logic [WAIT_CNT_W-1:0] cnt;
   logic                  err_q;
   logic                  addr_err;
   logic [IDX_W-1:0]      idx;
   logic                  mem_we;
   logic                  mem_re;
   logic                  unused_sig;

   assign idx = PADDR[LSB +: IDX_W];

`ifdef APB_SLV_ERR_EN
   logic hi_bad;
   logic lo_bad;

   generate
      if (PADDR_SIZE > LSB + IDX_W) begin : g_hi
         assign hi_bad = |PADDR[PADDR_SIZE-1:LSB+IDX_W];
      end else begin : g_no_hi
         assign hi_bad = 1'b0;
      end
      if (LSB > 0) begin : g_lo
         assign lo_bad = |PADDR[LSB-1:0];
      end else begin : g_no_lo
         assign lo_bad = 1'b0;
      end
   endgenerate

   assign addr_err = hi_bad | lo_bad;
   assign PSLVERR  = PREADY & err_q;
`else
   assign addr_err = 1'b0;
   assign PSLVERR  = 1'b0;
`endif

   assign unused_sig = ^{PPROT, PADDR, err_q};

   // The setup cycle is the first cycle the master drives PSEL & !PENABLE, so it is
   // decoded from IDLE rather than registered; this keeps transfers at 2+WAIT_STATES.
   always_comb begin
      phase = state;
      if (state == IDLE && PSEL && !PENABLE) phase = SETUP;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         case (phase)
            SETUP: begin
               state <= ACCESS;
               cnt   <= WAIT_CNT_W'(WAIT_STATES);
               err_q <= addr_err;
            end
            ACCESS: begin
               if (!PSEL || !PENABLE) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign PREADY = (state == ACCESS) && (cnt == '0);
   assign mem_re = (phase == SETUP) && !PWRITE;
   assign mem_we = PREADY && PSEL && PENABLE && PWRITE && !err_q;

   apb_slv_mem_array #(
      .DATA_W (PDATA_SIZE),
      .DEPTH  (MEM_DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk_sys (PCLK),
      .rst_b   (PRESETn),
      .we      (mem_we),
      .wstrb   (PSTRB),
      .widx    (idx),
      .wdata   (PWDATA),
      .re      (mem_re),
      .rd_zero (addr_err),
      .ridx    (idx),
      .rdata   (PRDATA)
   );

endmodule
